// File: rtl/logic_pkg.sv
// Shared definitions for the logic unit arbiter: datapath widths and op-select encodings.
package logic_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned SEL_W  = 3;

  typedef logic [SEL_W-1:0] lop_t;

  localparam lop_t LOP_AND   = 3'd0;
  localparam lop_t LOP_OR    = 3'd1;
  localparam lop_t LOP_XOR   = 3'd2;
  localparam lop_t LOP_NAND  = 3'd3;
  localparam lop_t LOP_NOR   = 3'd4;
  localparam lop_t LOP_XNOR  = 3'd5;
  localparam lop_t LOP_NOTA  = 3'd6;
  localparam lop_t LOP_PASSA = 3'd7;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational bitwise logic unit; every select value maps to a defined op.
module logic_unit
  import logic_pkg::*;
#(
  parameter int unsigned DATA_W = logic_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  lop_t              sel,
  output logic [DATA_W-1:0] y
);

  // Decode the op select into the bitwise result.
  always_comb begin
    y = '0;
    unique case (sel)
      LOP_AND:   y = a & b;
      LOP_OR:    y = a | b;
      LOP_XOR:   y = a ^ b;
      LOP_NAND:  y = ~(a & b);
      LOP_NOR:   y = ~(a | b);
      LOP_XNOR:  y = ~(a ^ b);
      LOP_NOTA:  y = ~a;
      LOP_PASSA: y = a;
      default:   y = a;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: searches ptr, ptr+1, ... (mod NUM_REQ) for the first request.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  // Pick the first requester at or after ptr; grant nothing when disabled.
  always_comb begin
    logic        found;
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one logic unit among NUM_REQ issue slots with round-robin grant and a
// single-entry result register that drains and refills on the same edge.
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = logic_pkg::DATA_W,
  parameter int unsigned SEL_W   = logic_pkg::SEL_W,
  parameter int unsigned TAG_W   = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic [ID_W-1:0]           res_id,
  output logic [TAG_W-1:0]          res_tag
);

  logic [DATA_W-1:0] a_arr   [NUM_REQ];
  logic [DATA_W-1:0] b_arr   [NUM_REQ];
  logic [SEL_W-1:0]  sel_arr [NUM_REQ];
  logic [TAG_W-1:0]  tag_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]   = req_a[i*DATA_W +: DATA_W];
    assign b_arr[i]   = req_b[i*DATA_W +: DATA_W];
    assign sel_arr[i] = req_sel[i*SEL_W +: SEL_W];
    assign tag_arr[i] = req_tag[i*TAG_W +: TAG_W];
  end

  logic              res_valid_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [SEL_W-1:0]  sel_q;
  logic [TAG_W-1:0]  tag_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   ptr_q;

  logic               can_accept;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               transfer;
  logic [ID_W-1:0]    ptr_next;

  // A held result blocks new grants until the consumer takes it; reset blocks all grants.
  assign can_accept = !res_valid_q || res_ready;
  assign arb_en     = can_accept && !rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .en        (arb_en),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is only ever raised on a valid slot, so any grant bit is a transfer.
  assign req_ready = grant;
  assign transfer  = |grant;
  assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Result register and rotating pointer; a transfer overrides the drain of the previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      tag_q       <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
    end else begin
      res_valid_q <= res_valid_q && !res_ready;
      if (transfer) begin
        a_q         <= a_arr[grant_idx];
        b_q         <= b_arr[grant_idx];
        sel_q       <= sel_arr[grant_idx];
        tag_q       <= tag_arr[grant_idx];
        id_q        <= grant_idx;
        res_valid_q <= 1'b1;
        ptr_q       <= ptr_next;
      end
    end
  end

  logic_unit #(
    .DATA_W (DATA_W)
  ) u_logic_unit (
    .a   (a_q),
    .b   (b_q),
    .sel (sel_q),
    .y   (res_data)
  );

  assign res_valid = res_valid_q;
  assign res_id    = id_q;
  assign res_tag   = tag_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed table-driven bench for logic_unit_arbiter with hand-computed expectations.
module tb_logic_unit_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned ID_W    = 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*SEL_W-1:0]  req_sel;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-1:0]         res_data;
  logic [ID_W-1:0]           res_id;
  logic [TAG_W-1:0]          res_tag;

  logic_unit_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .SEL_W   (SEL_W),
    .TAG_W   (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .req_tag   (req_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_tag   (res_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  valid;
    logic        rr;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  sel;
    logic [3:0]  tag_base;  // slot i is driven with tag_base + i
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic [1:0]  exp_id;
    logic [3:0]  exp_tag;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] valid, input logic rr, input logic [63:0] a,
                              input logic [63:0] b, input logic [2:0] sel,
                              input logic [3:0] tag_base, input logic [3:0] exp_ready,
                              input logic exp_valid, input logic [63:0] exp_data,
                              input logic [1:0] exp_id, input logic [3:0] exp_tag);
    vec_t v;
    v.valid = valid; v.rr = rr; v.a = a; v.b = b; v.sel = sel; v.tag_base = tag_base;
    v.exp_ready = exp_ready; v.exp_valid = exp_valid; v.exp_data = exp_data;
    v.exp_id = exp_id; v.exp_tag = exp_tag;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Valid slots get the vector operands; idle slots get inverted junk that must be ignored.
  task automatic drive(input logic [3:0] valid, input logic rr, input logic [63:0] a,
                       input logic [63:0] b, input logic [2:0] sel, input logic [3:0] tag_base);
    req_valid = valid;
    res_ready = rr;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = valid[i] ? a : ~a;
      req_b[i*DATA_W +: DATA_W] = valid[i] ? b : ~b;
      req_sel[i*SEL_W +: SEL_W] = valid[i] ? sel : ~sel;
      req_tag[i*TAG_W +: TAG_W] = tag_base + 4'(i);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    @(negedge clk);
    drive(v.valid, v.rr, v.a, v.b, v.sel, v.tag_base);
    #1;
    check({name, ".req_ready"}, 64'(req_ready), 64'(v.exp_ready));
    @(posedge clk);
    #1;
    check({name, ".res_valid"}, 64'(res_valid), 64'(v.exp_valid));
    if (v.exp_valid) begin
      check({name, ".res_data"}, res_data, v.exp_data);
      check({name, ".res_id"}, 64'(res_id), 64'(v.exp_id));
      check({name, ".res_tag"}, 64'(res_tag), 64'(v.exp_tag));
    end
  endtask

  localparam logic [63:0] RR_A  = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] RR_B  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] RR_Y  = 64'hFFFF_5678_FFFF_DEF0;
  localparam logic [63:0] S_A   = 64'h0000_0000_FF00_00F0;
  localparam logic [63:0] S_B   = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] S_Y   = 64'h0F0F_0F0F_F00F_0FFF;
  localparam logic [63:0] W_A   = 64'h0000_000F_FC00_0070;
  localparam logic [63:0] W_B   = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] BP_A  = 64'hAAAA_5555_0000_FFFF;
  localparam logic [63:0] BP_B  = 64'h0000_0000_1234_0000;
  localparam logic [63:0] BP_Y  = 64'hAAAA_5555_1234_FFFF;

  logic [63:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 64'h0000_000F_0C00_0000;  // AND
    sweep_exp[1] = 64'h0F0F_0F0F_FF0F_0F7F;  // OR
    sweep_exp[2] = 64'h0F0F_0F00_F30F_0F7F;  // XOR
    sweep_exp[3] = 64'hFFFF_FFF0_F3FF_FFFF;  // NAND
    sweep_exp[4] = 64'hF0F0_F0F0_00F0_F080;  // NOR
    sweep_exp[5] = 64'hF0F0_F0FF_0CF0_F080;  // XNOR
    sweep_exp[6] = 64'hFFFF_FFF0_03FF_FF8F;  // NOT A
    sweep_exp[7] = 64'h0000_000F_FC00_0070;  // pass A

    // Round robin straight out of reset: ids 0,1,2,3,0,1, ptr ends at 2.
    vecs.push_back(mk(4'b1111, 1'b1, RR_A, RR_B, 3'd1, 4'd0, 4'b0001, 1'b1, RR_Y, 2'd0, 4'd0));
    vecs.push_back(mk(4'b1111, 1'b1, RR_A, RR_B, 3'd1, 4'd0, 4'b0010, 1'b1, RR_Y, 2'd1, 4'd1));
    vecs.push_back(mk(4'b1111, 1'b1, RR_A, RR_B, 3'd1, 4'd0, 4'b0100, 1'b1, RR_Y, 2'd2, 4'd2));
    vecs.push_back(mk(4'b1111, 1'b1, RR_A, RR_B, 3'd1, 4'd0, 4'b1000, 1'b1, RR_Y, 2'd3, 4'd3));
    vecs.push_back(mk(4'b1111, 1'b1, RR_A, RR_B, 3'd1, 4'd0, 4'b0001, 1'b1, RR_Y, 2'd0, 4'd0));
    vecs.push_back(mk(4'b1111, 1'b1, RR_A, RR_B, 3'd1, 4'd0, 4'b0010, 1'b1, RR_Y, 2'd1, 4'd1));
    // Single XOR op from slot 2 with tag 5.
    vecs.push_back(mk(4'b0100, 1'b1, S_A, S_B, 3'd2, 4'd3, 4'b0100, 1'b1, S_Y, 2'd2, 4'd5));
    // Idle cycle drains the result.
    vecs.push_back(mk(4'b0000, 1'b1, S_A, S_B, 3'd2, 4'd3, 4'b0000, 1'b0, '0, 2'd0, 4'd0));
    // Op sweep from slot 3 (tag 3).
    for (int s = 0; s < 8; s++)
      vecs.push_back(mk(4'b1000, 1'b1, W_A, W_B, 3'(s), 4'd0, 4'b1000, 1'b1, sweep_exp[s],
                        2'd3, 4'd3));
    // Backpressure: result from the pass-A sweep op must hold for 3 cycles.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(4'b0010, 1'b0, BP_A, BP_B, 3'd1, 4'd0, 4'b0000, 1'b1, W_A, 2'd3, 4'd3));
    // Release: slot 1 accepted on the same edge the held result drains.
    vecs.push_back(mk(4'b0010, 1'b1, BP_A, BP_B, 3'd1, 4'd0, 4'b0010, 1'b1, BP_Y, 2'd1, 4'd1));
    vecs.push_back(mk(4'b0000, 1'b1, BP_A, BP_B, 3'd1, 4'd0, 4'b0000, 1'b0, '0, 2'd0, 4'd0));

    // Reset held 2 cycles with every slot requesting.
    rst = 1'b1;
    drive(4'b1111, 1'b1, RR_A, RR_B, 3'd1, 4'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("reset.req_ready", 64'(req_ready), 64'h0);
      @(posedge clk);
      #1;
      check("reset.res_valid", 64'(res_valid), 64'h0);
    end
    rst = 1'b0;

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Mid-op reset: ptr is 2 here, so slot 0 wins and moves ptr to 1.
    apply("midrst.load", mk(4'b0001, 1'b0, S_A, S_B, 3'd0, 4'd0, 4'b0001, 1'b1,
                            64'h0000_0000_0F00_0000, 2'd0, 4'd0));
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1111, 1'b0, RR_A, RR_B, 3'd1, 4'd0);
    #1;
    check("midrst.req_ready", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    check("midrst.res_valid", 64'(res_valid), 64'h0);
    rst = 1'b0;
    // Pointer must be back at 0, then advance normally.
    apply("midrst.after0", mk(4'b1111, 1'b1, RR_A, RR_B, 3'd1, 4'd0, 4'b0001, 1'b1, RR_Y,
                              2'd0, 4'd0));
    apply("midrst.after1", mk(4'b1111, 1'b1, RR_A, RR_B, 3'd1, 4'd0, 4'b0010, 1'b1, RR_Y,
                              2'd1, 4'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
